bram_burst_reader: RTL and testbench
====================================

// Module: bram_burst_reader
// PURPOSE
// - Parametrised BRAM-to-module loader: on read_start, issues a burst of read_len addresses from base_addr,
//   tracks BRAM read latency, packs returned words into NUM_MODULE_INPUT lanes, flags completion via 4-phase handshake.
// - Sits between weight/activation BRAM and compute modules; fixes fixed-1-cycle latency, fixed length, fixed start address.
// PARAMETERS
// - DATA_WIDTH        16  width of one BRAM word / one module lane
// - ADDR_WIDTH        12  BRAM address width
// - NUM_MODULE_INPUT   8  number of output lanes = max burst length
// - READ_LATENCY       2  BRAM clock cycles from address/enable to valid data (>=1)
// PORTS
// - clk            in   1                              system clock
// - reset_n        in   1                              asynchronous, active-low reset
// - read_start     in   1                              start request; level, held until read_done seen
// - base_addr      in   ADDR_WIDTH                     first BRAM address, sampled with read_start
// - read_len       in   $clog2(NUM_MODULE_INPUT+1)     words to read, sampled with read_start
// - BRAM_address   out  ADDR_WIDTH                     BRAM read address (registered)
// - BRAM_enable    out  1                              BRAM read enable
// - BRAM_data      in   DATA_WIDTH                     BRAM read data
// - module_inputs  out  [NUM_MODULE_INPUT][DATA_WIDTH] packed lanes; lane i = word i of burst
// - busy           out  1                              high in ISSUE/DRAIN
// - read_done      out  1                              high in DONE
// - len_error      out  1                              read_len > NUM_MODULE_INPUT on last start; sticky to next start
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; BRAM_address=0, BRAM_enable=0, module_inputs=0, busy=0, read_done=0,
//   len_error=0, issue/capture counters and valid pipe cleared. Reset mid-burst aborts; in-flight data discarded.
// - States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE: edge sampling read_start=1 latches base_addr into BRAM_address, len=min(read_len,NUM_MODULE_INPUT),
//   len_error=(read_len>NUM_MODULE_INPUT), clears lane index. len==0 -> DONE directly; else -> ISSUE.
// - ISSUE: BRAM_enable=1 every cycle; BRAM_address advances by step (1) each edge; after len issues -> DRAIN.
// - Valid pipe (READ_LATENCY deep) shifts 1 per issued read; when its last stage is set, BRAM_data is written to
//   module_inputs[lane_idx], lane_idx++. Issue and capture may occur in the same cycle.
// - DRAIN: BRAM_enable=0; DONE entered on the edge capturing word len-1.
// - Latency: read_done rises at edge len+READ_LATENCY counted from the edge sampling read_start (edge 0).
// - DONE: read_done=1, module_inputs stable; -> IDLE when read_start=0. Lanes >= len keep previous values.
// - read_start while busy or in DONE: ignored (no restart, no re-sample of base_addr/read_len).
// - Address arithmetic modulo 2**ADDR_WIDTH: 0xFFF + 1 wraps to 0x000 without error.
// - BRAM_address holds its last value outside ISSUE; BRAM_data ignored when valid pipe tail is 0.
// CONFIGURATION
// - BRAM_READ_STRIDE_EN defined: adds input port read_stride [ADDR_WIDTH] sampled with read_start; address step =
//   read_stride (0 = re-read same address len times); wrap rule unchanged.
// - BRAM_READ_STRIDE_EN undefined: port absent, step fixed at 1.
// TESTING
// - Reset low mid-ISSUE (len=8) -> all outputs 0 asynchronously, state IDLE; after release next start runs normally.
// - base=0x010, len=4, LAT=2, BRAM[i]=i*3 -> addresses 0x010..0x013 on 4 consecutive cycles, lanes0..3=0x30,0x33,0x36,0x39, read_done at edge 6.
// - base=0xFFE, len=4 -> addresses 0xFFE,0xFFF,0x000,0x001; lanes hold those words in order.
// - len=0 -> no BRAM_enable pulse, read_done at edge 1, module_inputs unchanged; len=9 (NIO=8) -> 8 reads, len_error=1.
// - read_done high, read_start kept 1 for 5 cycles -> stays DONE; drop read_start -> IDLE next edge; new start accepted.
// - BRAM_READ_STRIDE_EN, base=0x100, stride=4, len=3 -> addresses 0x100,0x104,0x108; stride=0 -> 0x100 three times.

Source files
------------

// File: rtl/bram_burst_reader.sv
// Burst reader: fetches up to NUM_MODULE_INPUT words from a pipelined BRAM into packed output lanes.
// Optional feature macro BRAM_READ_STRIDE_EN adds a per-burst address stride input (default step is 1).
module bram_burst_reader #(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 12,
  parameter int NUM_MODULE_INPUT = 8,
  parameter int READ_LATENCY     = 2
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             read_start,
  input  logic [ADDR_WIDTH-1:0]                            base_addr,
  input  logic [$clog2(NUM_MODULE_INPUT+1)-1:0]            read_len,
`ifdef BRAM_READ_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]                            read_stride,
`endif
  output logic [ADDR_WIDTH-1:0]                            BRAM_address,
  output logic                                             BRAM_enable,
  input  logic [DATA_WIDTH-1:0]                            BRAM_data,
  output logic [NUM_MODULE_INPUT-1:0][DATA_WIDTH-1:0]      module_inputs,
  output logic                                             busy,
  output logic                                             read_done,
  output logic                                             len_error
);

  localparam int LEN_W = $clog2(NUM_MODULE_INPUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_MODULE_INPUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        issue_cnt;
  logic [LEN_W-1:0]        lane_idx;
  logic [READ_LATENCY-1:0] vpipe;
  logic [ADDR_WIDTH-1:0]   step;
  logic                    capture;

`ifndef BRAM_READ_STRIDE_EN
  assign step = ADDR_WIDTH'(1);
`endif

  // The tail of the valid pipe marks the cycle in which BRAM_data belongs to this burst.
  assign capture = vpipe[READ_LATENCY-1];

  // Burst FSM with address issue, read-latency tracking and lane capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      issue_cnt     <= '0;
      lane_idx      <= '0;
      vpipe         <= '0;
      BRAM_address  <= '0;
      BRAM_enable   <= 1'b0;
      module_inputs <= '0;
      busy          <= 1'b0;
      read_done     <= 1'b0;
      len_error     <= 1'b0;
`ifdef BRAM_READ_STRIDE_EN
      step          <= '0;
`endif
    end else begin
      vpipe[0] <= BRAM_enable;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
      end

      if (capture && (state == ISSUE || state == DRAIN)) begin
        for (int i = 0; i < NUM_MODULE_INPUT; i++) begin
          if (lane_idx == LEN_W'(i)) begin
            module_inputs[i] <= BRAM_data;
          end
        end
        lane_idx <= lane_idx + LEN_W'(1);
      end

      case (state)
        IDLE: begin
          BRAM_enable <= 1'b0;
          if (read_start) begin
            BRAM_address <= base_addr;
            len_error    <= (read_len > MAX_LEN);
            lane_idx     <= '0;
`ifdef BRAM_READ_STRIDE_EN
            step         <= read_stride;
`endif
            if (read_len == '0) begin
              len   <= '0;
              state <= DONE;
            end else begin
              len         <= (read_len > MAX_LEN) ? MAX_LEN : read_len;
              issue_cnt   <= LEN_W'(1);
              BRAM_enable <= 1'b1;
              busy        <= 1'b1;
              state       <= ISSUE;
            end
          end
        end

        ISSUE: begin
          // issue_cnt counts reads already presented to the BRAM.
          if (issue_cnt == len) begin
            BRAM_enable <= 1'b0;
            state       <= DRAIN;
          end else begin
            BRAM_address <= BRAM_address + step;
            issue_cnt    <= issue_cnt + LEN_W'(1);
          end
        end

        DRAIN: begin
          BRAM_enable <= 1'b0;
          if (capture && (lane_idx == len - LEN_W'(1))) begin
            busy      <= 1'b0;
            read_done <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          BRAM_enable <= 1'b0;
          busy        <= 1'b0;
          // A zero-length burst arrives here with read_done still low; raise it one cycle later.
          if (!read_done) begin
            read_done <= 1'b1;
          end else if (!read_start) begin
            read_done <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          BRAM_enable <= 1'b0;
          busy        <= 1'b0;
          read_done   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: table of bursts against a latency-2 BRAM model whose word at a is a*3.
module tb_bram_burst_reader;

  logic                  clk;
  logic                  reset_n;
  logic                  read_start;
  logic [11:0]           base_addr;
  logic [3:0]            read_len;
  logic [11:0]           read_stride_v;
  logic [11:0]           BRAM_address;
  logic                  BRAM_enable;
  logic [15:0]           BRAM_data;
  logic [7:0][15:0]      module_inputs;
  logic                  busy;
  logic                  read_done;
  logic                  len_error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] mlane [8];
  logic [15:0] bram_r1;
  logic [15:0] bram_r2;

  bram_burst_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(12), .NUM_MODULE_INPUT(8), .READ_LATENCY(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .read_start(read_start),
    .base_addr(base_addr),
    .read_len(read_len),
`ifdef BRAM_READ_STRIDE_EN
    .read_stride(read_stride_v),
`endif
    .BRAM_address(BRAM_address),
    .BRAM_enable(BRAM_enable),
    .BRAM_data(BRAM_data),
    .module_inputs(module_inputs),
    .busy(busy),
    .read_done(read_done),
    .len_error(len_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [11:0] a);
    return 16'({4'd0, a} * 16'd3);
  endfunction

  // Two-register BRAM read pipeline; non-enabled cycles return a marker value.
  always @(posedge clk) begin
    bram_r1 <= BRAM_enable ? word_at(BRAM_address) : 16'hDEAD;
    bram_r2 <= bram_r1;
  end
  assign BRAM_data = bram_r2;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lanes(input string name);
    for (int i = 0; i < 8; i++) begin
      check(name, module_inputs[i], mlane[i]);
    end
  endtask

  task automatic run_burst(input logic [11:0] b, input logic [3:0] l, input logic [11:0] s,
                           input int eff, input logic err, input int done_edge, input int hold);
    int          e;
    int          n;
    logic        done;
    logic        seen_busy;
    logic [11:0] a;
    @(negedge clk);
    base_addr     = b;
    read_len      = l;
    read_stride_v = s;
    read_start    = 1'b1;
    @(posedge clk); #1;
    e = 0; n = 0; a = b; done = 1'b0; seen_busy = 1'b0;
    while (e < 30 && !done) begin
      if (BRAM_enable) begin
        check("issue_addr", BRAM_address, a);
        a = a + s;
        n++;
      end
      if (busy) seen_busy = 1'b1;
      if (read_done) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        base_addr     = ~b;
        read_len      = 4'd3;
        read_stride_v = s + 12'd1;
        @(posedge clk); #1;
        e++;
      end
    end
    check("done_edge", e, done_edge);
    check("read_count", n, eff);
    check("busy_seen", seen_busy, (eff != 0));
    check("busy_in_done", busy, 1'b0);
    check("len_error", len_error, err);
    a = b;
    for (int i = 0; i < eff; i++) begin
      mlane[i] = word_at(a);
      a = a + s;
    end
    check_lanes("lanes");
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); @(posedge clk); #1;
      check("hold_done", read_done, 1'b1);
      check("hold_no_read", BRAM_enable, 1'b0);
    end
    if (hold > 0) check_lanes("lanes_after_hold");
    @(negedge clk);
    read_start = 1'b0;
    @(posedge clk); #1;
    check("release_done", read_done, 1'b0);
    check("err_sticky", len_error, err);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [3:0]  len;
    int          eff;
    logic        err;
    int          done_edge;
    int          hold;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{12'h010, 4'd4,  4, 1'b0,  6, 5};
    vt[1] = '{12'hFFE, 4'd4,  4, 1'b0,  6, 0};
    vt[2] = '{12'h000, 4'd0,  0, 1'b0,  1, 2};
    vt[3] = '{12'h200, 4'd9,  8, 1'b1, 10, 0};
    vt[4] = '{12'h123, 4'd1,  1, 1'b0,  3, 0};
    vt[5] = '{12'h050, 4'd2,  2, 1'b0,  4, 1};
    vt[6] = '{12'h7F0, 4'd15, 8, 1'b1, 10, 0};

    for (int i = 0; i < 8; i++) mlane[i] = 16'h0000;
    reset_n       = 1'b0;
    read_start    = 1'b0;
    base_addr     = 12'h000;
    read_len      = 4'd0;
    read_stride_v = 12'd1;
    @(negedge clk);
    check("rst_addr", BRAM_address, 12'h000);
    check("rst_enable", BRAM_enable, 1'b0);
    check("rst_lanes", module_inputs, 128'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", read_done, 1'b0);
    check("rst_err", len_error, 1'b0);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_burst(vt[v].base, vt[v].len, 12'd1, vt[v].eff, vt[v].err, vt[v].done_edge, vt[v].hold);
    end

    // Asynchronous reset in the middle of an 8-word burst, after two lanes were captured.
    @(negedge clk);
    base_addr  = 12'h400;
    read_len   = 4'd8;
    read_start = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", BRAM_address, 12'h000);
    check("mid_rst_enable", BRAM_enable, 1'b0);
    check("mid_rst_lanes", module_inputs, 128'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", read_done, 1'b0);
    check("mid_rst_err", len_error, 1'b0);
    read_start = 1'b0;
    for (int i = 0; i < 8; i++) mlane[i] = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    run_burst(12'h0A0, 4'd3, 12'd1, 3, 1'b0, 5, 0);

`ifdef BRAM_READ_STRIDE_EN
    run_burst(12'h100, 4'd3, 12'd4, 3, 1'b0, 5, 0);
    run_burst(12'h100, 4'd3, 12'd0, 3, 1'b0, 5, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
